nand_flash_responder: RTL and testbench
=======================================

// Module: nand_flash_responder
// PURPOSE
//  Target (device) end of the small-page NAND bus driven by the NFC controller: decodes CLE/ALE/WEN/REN
//  cycles, holds a 512-byte page register, drives F_RB busy, and moves pages to/from a backing byte array
//  over a req/ack memory port. Replaces the behavioural flash models where a synthesizable target is required.
// PARAMETERS
//  COL_W   9    column address bits (page = 2**COL_W bytes)
//  ROW_W   9    page address bits (2**ROW_W pages)
//  T_R     25   minimum F_RB-low clk cycles for page read (array -> page register)
//  T_PROG  100  minimum F_RB-low clk cycles for page program (page register -> array)
//  T_RST   5    F_RB-low clk cycles after an FFh reset command
// PORTS
//  clk        in   1              system clock; all bus signals are synchronous to it
//  rst        in   1              synchronous, active-high reset
//  F_IO_I     in   8              bus data from the host
//  F_IO_O     out  8              bus data to the host
//  F_IO_OE    out  1              1 = drive F_IO_O onto the bus
//  F_CLE      in   1              command latch enable
//  F_ALE      in   1              address latch enable
//  F_WEN      in   1              write enable, active low; latch on rising edge
//  F_REN      in   1              read enable, active low
//  F_RB       out  1              ready(1) / busy(0)
//  mem_req    out  1              array access request; held until mem_ack
//  mem_we     out  1              1 = write, 0 = read
//  mem_addr   out  COL_W+ROW_W    byte address {row, col}
//  mem_wdata  out  8              write data
//  mem_rdata  in   8              read data, valid with mem_ack
//  mem_ack    in   1              one-cycle access complete
// BEHAVIOUR
//  - Reset: F_RB=1, F_IO_OE=0, F_IO_O=0, mem_req=0, mem_we=0, FSM=IDLE, col/row=0. Page register not reset.
//  - WEN/REN edges come from a 1-cycle registered copy; a WEN rise is acted on in that cycle (1-clk latency).
//  - WEN rise decode: CLE=1,ALE=0 -> command; ALE=1,CLE=0 -> address; both 0 -> data (DIN only);
//    both 1 -> ignored. WEN rise and REN fall in the same cycle: WEN wins, the REN fall is dropped.
//  - Commands: 00h read, col base 0; 01h read, col base 256; 80h data input (page register set to FFh that cycle,
//    col base 0); 10h program confirm (only valid in DIN); 70h status; FFh reset. Any other or out-of-sequence
//    command is ignored.
//  - Address: 3 WEN cycles: col[7:0] (added to col base), row[7:0], row[8] (bit0; upper bits ignored).
//  - FSM: IDLE -> ADDR(cmd 00/01/80) -> LOAD(read) | DIN(80h); DIN -10h-> PROG; LOAD/PROG/RSTB -> IDLE/DOUT.
//  - LOAD: F_RB=0 the cycle after the 3rd address byte; 512 sequential mem reads fill the page register;
//    F_RB returns to 1 when all acks are received AND T_R cycles have elapsed; then DOUT at the addressed column.
//  - DOUT: on REN fall, F_IO_O=page[col], F_IO_OE=1 until REN rise; col+1 on REN rise. col past 511 -> FFh, no wrap.
//  - DIN: each data byte is written to page[col], col+1; writes past col 511 are dropped.
//  - PROG: F_RB=0 on the cycle after 10h; 512 mem writes of the page register; done by the same rule as LOAD with T_PROG.
//  - mem handshake: req/we/addr/wdata stable until ack; next request no earlier than the cycle after ack.
//  - While F_RB=0 only FFh (and 70h when enabled) is accepted. FFh: finish any outstanding mem access
//    (never drop req before ack), stop the sequence, hold F_RB=0 for T_RST cycles -> IDLE.
//  - rst mid-operation: immediate return to reset values; mem_req drops regardless of ack.
// CONFIGURATION
//  STATUS_READ_EN defined: 70h enters STAT; every REN-low cycle drives {1'b1, F_RB, 6'b0}
//    (ready = C0h, busy = 80h) until the next command. Accepted while busy.
//  STATUS_READ_EN undefined: 70h ignored; F_IO_OE stays 0.
// STRUCTURE
//  Package nand_resp_pkg: opcode constants (CMD_READ0/READ1/SEQIN/PROG/STATUS/RESET), FSM state enum,
//    status bit positions, PAGE_BYTES.
//  Sub-module nand_page_buf: 2**COL_W x 8 register array with one write port, one read port, and a fill-FFh input.
// TESTING
//  1 rst pulse -> F_RB=1, F_IO_OE=0, mem_req=0; no mem activity for 50 cycles.
//  2 80h, addr 00/05/00, 512 bytes i%256, 10h -> F_RB=0 >=100 cycles; writes addr 5*512+i data i%256; F_RB=1.
//  3 00h, addr 00/05/00 -> F_RB=0 >=25 cycles, 512 reads; 512 REN pulses return i%256; 513th returns FFh.
//  4 01h, addr 10h/05/00 -> first REN byte = page[0x110] = 10h.
//  5 FFh mid-PROG with mem_ack delayed 3 cycles -> req held to ack, no new req; F_RB=0 5 cycles, then IDLE.
//  6 70h during LOAD -> 80h; after ready -> C0h; build without STATUS_READ_EN -> F_IO_OE never asserts.

Source files
------------

// File: rtl/nand_resp_pkg.sv
// Shared definitions for the NAND flash target (device) model.
//   Opcodes: CMD_READ0/READ1/SEQIN/PROG/STATUS/RESET.
//   FSM state enum: state_t.
//   Status byte bit positions: STAT_WP_BIT (not write-protected), STAT_RDY_BIT (ready).
//   PAGE_BYTES: data bytes per page in the default geometry.
package nand_resp_pkg;

    localparam logic [7:0] CMD_READ0  = 8'h00;
    localparam logic [7:0] CMD_READ1  = 8'h01;
    localparam logic [7:0] CMD_SEQIN  = 8'h80;
    localparam logic [7:0] CMD_PROG   = 8'h10;
    localparam logic [7:0] CMD_STATUS = 8'h70;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam int PAGE_BYTES   = 512;
    localparam int STAT_WP_BIT  = 7;
    localparam int STAT_RDY_BIT = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LOAD,
        ST_DOUT,
        ST_DIN,
        ST_PROG,
        ST_RSTB
    } state_t;

endpackage

// File: rtl/nand_page_buf.sv
// Page register of the NAND target: 2**COL_W bytes held in flops.
//   clk    in   clock
//   fill   in   set every byte to FFh (has priority over we)
//   we     in   write enable for waddr/wdata
//   waddr  in   write byte address
//   wdata  in   write byte
//   raddr  in   read byte address
//   rdata  out  combinational read data
// No reset: contents are undefined until filled or written.
module nand_page_buf #(
    parameter int COL_W = 9
) (
    input  logic             clk,
    input  logic             fill,
    input  logic             we,
    input  logic [COL_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [COL_W-1:0] raddr,
    output logic [7:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** COL_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (fill) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'hFF;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nand_flash_responder.sv
// Synthesizable small-page NAND target driven by the NFC controller.
// Decodes CLE/ALE/WEN/REN bus cycles, keeps a page register, drives F_RB and
// moves whole pages to/from a backing byte array over a req/ack port.
//   clk, rst             clock, synchronous active-high reset
//   F_IO_I / F_IO_O      bus data in / out, F_IO_OE enables the output
//   F_CLE, F_ALE         command / address latch enables
//   F_WEN, F_REN         active-low write / read strobes
//   F_RB                 ready(1) / busy(0)
//   mem_req/we/addr/wdata  array access, held until mem_ack
//   mem_rdata, mem_ack   array read data, one-cycle completion
// Build option: define STATUS_READ_EN to enable the 70h status read.
module nand_flash_responder
    import nand_resp_pkg::*;
#(
    parameter int COL_W  = 9,
    parameter int ROW_W  = 9,
    parameter int T_R    = 25,
    parameter int T_PROG = 100,
    parameter int T_RST  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             F_IO_I,
    output logic [7:0]             F_IO_O,
    output logic                   F_IO_OE,
    input  logic                   F_CLE,
    input  logic                   F_ALE,
    input  logic                   F_WEN,
    input  logic                   F_REN,
    output logic                   F_RB,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [COL_W+ROW_W-1:0] mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_ack
);

    localparam int              CW       = COL_W + 1;
    localparam logic [COL_W:0]  COL_HALF = CW'(2 ** (COL_W - 1));
    localparam logic [15:0]     R_LAST   = 16'(T_R - 1);
    localparam logic [15:0]     P_LAST   = 16'(T_PROG - 1);
    localparam logic [15:0]     RST_LAST = 16'(T_RST - 1);

    state_t state, state_nxt;

    logic                   wen_q, ren_q;
    logic                   wen_rise, ren_fall, ren_rise;
    // col/xfer carry one extra bit: set means "past the last byte".
    logic [COL_W:0]         col, col_nxt;
    logic [COL_W:0]         col_base, col_base_nxt;
    logic [ROW_W-1:0]       row, row_nxt;
    logic [1:0]             addr_cnt, addr_cnt_nxt;
    logic                   is_read, is_read_nxt;
    logic [COL_W:0]         xfer, xfer_nxt;
    logic [15:0]            timer, timer_nxt;
    logic                   stat_mode, stat_mode_nxt;
    logic                   rb_nxt, req_nxt, we_nxt, io_oe_nxt;
    logic [COL_W+ROW_W-1:0] addr_nxt;
    logic [7:0]             wdata_nxt, io_o_nxt;

    logic                   buf_fill, buf_we;
    logic [COL_W-1:0]       buf_waddr, buf_raddr;
    logic [7:0]             buf_wdata, buf_rdata;

    assign wen_rise = F_WEN & ~wen_q;
    assign ren_fall = ~F_REN & ren_q;
    assign ren_rise = F_REN & ~ren_q;

    assign buf_raddr = (state == ST_PROG) ? xfer[COL_W-1:0] : col[COL_W-1:0];

    nand_page_buf #(
        .COL_W (COL_W)
    ) u_page (
        .clk   (clk),
        .fill  (buf_fill),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wen_q     <= 1'b1;
            ren_q     <= 1'b1;
            col       <= '0;
            col_base  <= '0;
            row       <= '0;
            addr_cnt  <= '0;
            is_read   <= 1'b0;
            xfer      <= '0;
            timer     <= '0;
            stat_mode <= 1'b0;
            F_RB      <= 1'b1;
            F_IO_O    <= '0;
            F_IO_OE   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            wen_q     <= F_WEN;
            ren_q     <= F_REN;
            col       <= col_nxt;
            col_base  <= col_base_nxt;
            row       <= row_nxt;
            addr_cnt  <= addr_cnt_nxt;
            is_read   <= is_read_nxt;
            xfer      <= xfer_nxt;
            timer     <= timer_nxt;
            stat_mode <= stat_mode_nxt;
            F_RB      <= rb_nxt;
            F_IO_O    <= io_o_nxt;
            F_IO_OE   <= io_oe_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        col_base_nxt  = col_base;
        row_nxt       = row;
        addr_cnt_nxt  = addr_cnt;
        is_read_nxt   = is_read;
        xfer_nxt      = xfer;
        timer_nxt     = (timer != '1) ? timer + 16'd1 : timer;
        stat_mode_nxt = stat_mode;
        rb_nxt        = F_RB;
        io_o_nxt      = F_IO_O;
        io_oe_nxt     = F_IO_OE;
        req_nxt       = mem_req;
        we_nxt        = mem_we;
        addr_nxt      = mem_addr;
        wdata_nxt     = mem_wdata;
        buf_fill      = 1'b0;
        buf_we        = 1'b0;
        buf_waddr     = col[COL_W-1:0];
        buf_wdata     = F_IO_I;

        // Array sequencer: one access at a time; req drops on ack and the
        // next one is raised no earlier than the following cycle.
        if (mem_req && mem_ack) begin
            req_nxt  = 1'b0;
            we_nxt   = 1'b0;
            xfer_nxt = xfer + 1'b1;
            if (state == ST_LOAD) begin
                buf_we    = 1'b1;
                buf_waddr = xfer[COL_W-1:0];
                buf_wdata = mem_rdata;
            end
        end else if (!mem_req && !xfer[COL_W] && (state == ST_LOAD || state == ST_PROG)) begin
            req_nxt   = 1'b1;
            we_nxt    = (state == ST_PROG);
            addr_nxt  = {row, xfer[COL_W-1:0]};
            wdata_nxt = buf_rdata;
        end

        case (state)
            ST_LOAD: if (xfer_nxt[COL_W] && !req_nxt && timer >= R_LAST) begin
                rb_nxt    = 1'b1;
                state_nxt = ST_DOUT;
            end
            ST_PROG: if (xfer_nxt[COL_W] && !req_nxt && timer >= P_LAST) begin
                rb_nxt    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_RSTB: if (!req_nxt && timer >= RST_LAST) begin
                rb_nxt    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: ;
        endcase

        // Data out; a REN fall coinciding with a WEN rise is dropped, and
        // col only advances for a REN pulse that actually drove the bus.
        if (state == ST_DOUT && !stat_mode && !wen_rise) begin
            if (ren_fall) begin
                io_oe_nxt = 1'b1;
                io_o_nxt  = col[COL_W] ? 8'hFF : buf_rdata;
            end else if (ren_rise && F_IO_OE) begin
                io_oe_nxt = 1'b0;
                if (!col[COL_W]) col_nxt = col + 1'b1;
            end
        end

`ifdef STATUS_READ_EN
        if (stat_mode) begin
            io_oe_nxt = ~F_REN;
            if (!F_REN) begin
                io_o_nxt               = '0;
                io_o_nxt[STAT_WP_BIT]  = 1'b1;
                io_o_nxt[STAT_RDY_BIT] = F_RB;
            end
        end
`endif

        if (wen_rise && F_CLE && !F_ALE) begin
            if (F_IO_I == CMD_RESET) begin
                // Let an outstanding access complete; never start a new one.
                req_nxt       = mem_req & ~mem_ack;
                we_nxt        = req_nxt & mem_we;
                state_nxt     = ST_RSTB;
                rb_nxt        = 1'b0;
                timer_nxt     = '0;
                io_oe_nxt     = 1'b0;
                stat_mode_nxt = 1'b0;
`ifdef STATUS_READ_EN
            end else if (F_IO_I == CMD_STATUS) begin
                stat_mode_nxt = 1'b1;
                io_oe_nxt     = 1'b0;
`endif
            end else if (F_RB) begin
                case (F_IO_I)
                    CMD_READ0, CMD_READ1, CMD_SEQIN: begin
                        if (state == ST_IDLE || state == ST_DOUT) begin
                            state_nxt     = ST_ADDR;
                            addr_cnt_nxt  = '0;
                            is_read_nxt   = (F_IO_I != CMD_SEQIN);
                            col_base_nxt  = (F_IO_I == CMD_READ1) ? COL_HALF : '0;
                            buf_fill      = (F_IO_I == CMD_SEQIN);
                            io_oe_nxt     = 1'b0;
                            stat_mode_nxt = 1'b0;
                        end
                    end
                    CMD_PROG: begin
                        if (state == ST_DIN) begin
                            state_nxt     = ST_PROG;
                            rb_nxt        = 1'b0;
                            xfer_nxt      = '0;
                            timer_nxt     = '0;
                            stat_mode_nxt = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (wen_rise && F_ALE && !F_CLE && F_RB && state == ST_ADDR) begin
            addr_cnt_nxt = addr_cnt + 2'd1;
            case (addr_cnt)
                2'd0:    col_nxt = col_base + CW'(F_IO_I);
                2'd1:    row_nxt[7:0] = F_IO_I;
                default: begin
                    row_nxt[ROW_W-1:8] = F_IO_I[ROW_W-9:0];
                    if (is_read) begin
                        state_nxt = ST_LOAD;
                        rb_nxt    = 1'b0;
                        xfer_nxt  = '0;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = ST_DIN;
                    end
                end
            endcase
        end else if (wen_rise && !F_ALE && !F_CLE && F_RB && state == ST_DIN) begin
            if (!col[COL_W]) begin
                buf_we  = 1'b1;
                col_nxt = col + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed bench for nand_flash_responder: drives the NAND bus through
// program, read, column-offset read, reset-during-program and status reads
// against a byte-array memory model with programmable ack delay.
`timescale 1ns/1ps
module tb_nand_flash_responder;
    import nand_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  F_IO_I, F_IO_O;
    logic        F_IO_OE, F_CLE, F_ALE, F_WEN, F_REN, F_RB;
    logic        mem_req, mem_we, mem_ack;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    nand_flash_responder dut (
        .clk       (clk),
        .rst       (rst),
        .F_IO_I    (F_IO_I),
        .F_IO_O    (F_IO_O),
        .F_IO_OE   (F_IO_OE),
        .F_CLE     (F_CLE),
        .F_ALE     (F_ALE),
        .F_WEN     (F_WEN),
        .F_REN     (F_REN),
        .F_RB      (F_RB),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Byte-array model; also audits the req/ack handshake.
    logic [7:0]  mem_arr [2**18];
    int          ack_delay  = 0;
    int          wait_cnt   = 0;
    int          n_wr       = 0;
    int          n_rd       = 0;
    int          n_req_rise = 0;
    int          hs_err     = 0;
    logic        in_txn     = 1'b0;
    logic [17:0] cap_addr;
    logic        cap_we;
    logic [7:0]  cap_wdata;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                in_txn  = 1'b0;
                if (mem_req === 1'b1) hs_err++;
            end else if (mem_req === 1'b1) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    n_req_rise++;
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                    wait_cnt  = 0;
                end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                             (cap_we && mem_wdata !== cap_wdata)) begin
                    hs_err++;
                end
                if (wait_cnt >= ack_delay) begin
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                        n_wr++;
                    end else begin
                        mem_rdata = mem_arr[mem_addr];
                        n_rd++;
                    end
                    mem_ack = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else if (in_txn) begin
                hs_err++;
                in_txn = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic cle, input logic ale, input logic [7:0] d);
        @(negedge clk);
        F_CLE  = cle;
        F_ALE  = ale;
        F_IO_I = d;
        F_WEN  = 1'b0;
        @(negedge clk);
        F_WEN  = 1'b1;
        @(negedge clk);
        F_CLE  = 1'b0;
        F_ALE  = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);
        bus_write(1'b1, 1'b0, d);
    endtask

    task automatic addr3(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        bus_write(1'b0, 1'b1, a0);
        bus_write(1'b0, 1'b1, a1);
        bus_write(1'b0, 1'b1, a2);
    endtask

    task automatic bus_read(output logic [7:0] d, output logic oe);
        @(negedge clk);
        F_REN = 1'b0;
        @(negedge clk);
        d     = F_IO_O;
        oe    = F_IO_OE;
        F_REN = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready(input int budget, output int low);
        low = 0;
        while (F_RB !== 1'b1 && low < budget) begin
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          low, base_rd, base_wr, base_rise, bad, k;
        logic [7:0]  d;
        logic        oe;
        logic [7:0]  first_b, last_b;

        rst = 1'b1; F_IO_I = '0; F_CLE = 1'b0; F_ALE = 1'b0; F_WEN = 1'b1; F_REN = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset values and an idle array port
        check_eq("rst_rb",    F_RB,    1);
        check_eq("rst_oe",    F_IO_OE, 0);
        check_eq("rst_io",    F_IO_O,  0);
        check_eq("rst_req",   mem_req, 0);
        check_eq("rst_we",    mem_we,  0);
        repeat (50) @(negedge clk);
        check_eq("idle_reqs", n_req_rise, 0);

        // 2: program row 5 with i%256; a 513th byte must be dropped
        cmd(CMD_SEQIN);
        addr3(8'h00, 8'h05, 8'h00);
        for (int i = 0; i < 512; i++) bus_write(1'b0, 1'b0, 8'(i % 256));
        bus_write(1'b0, 1'b0, 8'hAA);
        base_wr = n_wr;
        cmd(CMD_PROG);
        check_eq("prog_busy", F_RB, 0);
        wait_ready(20000, low);
        check_eq("prog_ready", F_RB, 1);
        check_eq("prog_min_busy", (low >= 100), 1);
        check_eq("prog_writes", n_wr - base_wr, 512);
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem_arr[5*512 + i] !== 8'(i % 256)) bad++;
        check_eq("prog_data_bad", bad, 0);
        check_eq("prog_byte0", mem_arr[5*512], 8'h00);

        // 3: read row 5 from column 0, then run past the page end
        base_rd = n_rd;
        cmd(CMD_READ0);
        addr3(8'h00, 8'h05, 8'h00);
        check_eq("load_busy", F_RB, 0);
        wait_ready(20000, low);
        check_eq("load_ready", F_RB, 1);
        check_eq("load_min_busy", (low >= 25), 1);
        check_eq("load_reads", n_rd - base_rd, 512);
        bad = 0;
        first_b = '0;
        last_b  = '0;
        for (int i = 0; i < 512; i++) begin
            bus_read(d, oe);
            if (d !== 8'(i % 256) || oe !== 1'b1) bad++;
            if (i == 0)   first_b = d;
            if (i == 511) last_b  = d;
        end
        check_eq("dout_bad",   bad, 0);
        check_eq("dout_first", first_b, 8'h00);
        check_eq("dout_last",  last_b,  8'hFF);
        bus_read(d, oe);
        check_eq("dout_513",    d,  8'hFF);
        check_eq("dout_513_oe", oe, 1);
        bus_read(d, oe);
        check_eq("dout_514",    d,  8'hFF);
        check_eq("oe_idle",     F_IO_OE, 0);

        // 4: 01h with column 10h starts at page[0x110]
        cmd(CMD_READ1);
        addr3(8'h10, 8'h05, 8'h00);
        wait_ready(20000, low);
        check_eq("rd1_ready", F_RB, 1);
        bus_read(d, oe);
        check_eq("rd1_first", d, 8'h10);
        bus_read(d, oe);
        check_eq("rd1_second", d, 8'h11);
        // CLE and ALE both high must be ignored
        bus_write(1'b1, 1'b1, CMD_SEQIN);
        bus_read(d, oe);
        check_eq("cle_ale_ignored", d, 8'h12);

        // 5: reset in the middle of a program with a slow array
        cmd(CMD_SEQIN);
        addr3(8'h00, 8'h05, 8'h00);
        ack_delay = 3;
        base_wr = n_wr;
        cmd(CMD_PROG);
        k = 0;
        while (!((n_wr - base_wr) >= 4 && mem_req === 1'b1) && k < 5000) begin
            k++;
            @(negedge clk);
        end
        check_eq("mid_prog_reached", (k < 5000), 1);
        cmd(CMD_RESET);
        base_rise = n_req_rise;
        wait_ready(1000, low);
        check_eq("rst_busy_cycles", low, 5);
        repeat (20) @(negedge clk);
        check_eq("rst_no_new_req", n_req_rise - base_rise, 0);
        check_eq("rst_req_low",    mem_req, 0);
        check_eq("rst_stopped",    ((n_wr - base_wr) < 20), 1);
        check_eq("rst_rb_ready",   F_RB, 1);
        ack_delay = 0;

        // 6: status read
        cmd(CMD_READ0);
        addr3(8'h00, 8'h05, 8'h00);
        cmd(CMD_STATUS);
        bus_read(d, oe);
`ifdef STATUS_READ_EN
        check_eq("stat_busy",    d,  8'h80);
        check_eq("stat_busy_oe", oe, 1);
        wait_ready(20000, low);
        bus_read(d, oe);
        check_eq("stat_ready",    d,  8'hC0);
        check_eq("stat_ready_oe", oe, 1);
`else
        check_eq("stat_off_busy_oe", oe, 0);
        wait_ready(20000, low);
        cmd(CMD_RESET);
        wait_ready(1000, low);
        cmd(CMD_STATUS);
        bus_read(d, oe);
        check_eq("stat_off_idle_oe", oe, 0);
`endif
        check_eq("handshake_errors", hs_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
